pc_mux: RTL and testbench

//  - Next-PC source selector for the RAT MCU program counter, placed between the control unit and the PC register.
//  - DIN is purely combinational. It selects one of four sources: the branch/jump immediate, the stack return address, the interrupt vector, or zero.
//  - A registered shadow (DIN_Q, SEL_Q, INTR_TAKEN) gives the control unit and debug logic a one-cycle-delayed view of the choice.

---
 rtl/pc_mux_pkg.sv | 19 +
 rtl/pc_mux_sat_cnt.sv | 38 +++
 rtl/pc_mux.sv | 114 +++++++++++
 tb/tb_pc_mux.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pc_mux_pkg.sv
// pc_mux_pkg: shared types and constants for the RAT MCU next-PC selector.
//   pc_sel_t      encoding of the PC_MUX_SEL source select
//   PC_WIDTH      program-counter address width
//   PC_INTR_ADDR  interrupt vector address
//   PC_ZERO_ADDR  reset vector address
package pc_mux_pkg;

  typedef enum logic [1:0] {
    PC_SEL_IMMED = 2'd0,
    PC_SEL_STACK = 2'd1,
    PC_SEL_INTR  = 2'd2,
    PC_SEL_ZERO  = 2'd3
  } pc_sel_t;

  localparam int               PC_WIDTH     = 10;
  localparam logic [PC_WIDTH-1:0] PC_INTR_ADDR = 10'h3FF;
  localparam logic [PC_WIDTH-1:0] PC_ZERO_ADDR = 10'h000;

endpackage

// File: rtl/pc_mux_sat_cnt.sv
// pc_mux_sat_cnt: saturating up-counter used for PC source tracing.
// Only compiled when PC_MUX_TRACE_EN is defined, since nothing else uses it.
//   clk  in   1      rising-edge clock
//   rst  in   1      asynchronous active-high reset, clears the count
//   en   in   1      count enable
//   cnt  out  CNT_W  current count, holds at all-ones
`ifdef PC_MUX_TRACE_EN
module pc_mux_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule
`endif

// File: rtl/pc_mux.sv
// pc_mux: next-PC source selector between the control unit and the PC register.
// DIN is purely combinational; DIN_Q / SEL_Q / INTR_TAKEN are a one-cycle
// delayed shadow of the selection for the control unit and debug logic.
// Optional macro PC_MUX_TRACE_EN adds four 16-bit saturating usage counters.
//   CLK         in   1      rising-edge clock
//   RST         in   1      asynchronous active-high reset (shadows only)
//   FROM_IMMED  in   WIDTH  branch/jump immediate target
//   FROM_STACK  in   WIDTH  return address from the stack
//   PC_MUX_SEL  in   2      source select (pc_sel_t encoding)
//   DIN         out  WIDTH  selected next-PC, combinational
//   DIN_Q       out  WIDTH  DIN registered
//   SEL_Q       out  2      PC_MUX_SEL registered
//   INTR_TAKEN  out  1      registered (PC_MUX_SEL == interrupt)
//   CNT_IMMED/CNT_STACK/CNT_INTR/CNT_ZERO  out 16  (PC_MUX_TRACE_EN only)
module pc_mux
  import pc_mux_pkg::*;
#(
  parameter int               WIDTH     = PC_WIDTH,
  parameter logic [WIDTH-1:0] INTR_ADDR = PC_INTR_ADDR,
  parameter logic [WIDTH-1:0] ZERO_ADDR = PC_ZERO_ADDR
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] FROM_IMMED,
  input  logic [WIDTH-1:0] FROM_STACK,
  input  logic [1:0]       PC_MUX_SEL,
  output logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] DIN_Q,
  output logic [1:0]       SEL_Q,
  output logic             INTR_TAKEN
`ifdef PC_MUX_TRACE_EN
  ,
  output logic [15:0]      CNT_IMMED,
  output logic [15:0]      CNT_STACK,
  output logic [15:0]      CNT_INTR,
  output logic [15:0]      CNT_ZERO
`endif
);

  logic [WIDTH-1:0] din_sh_d;
  logic [WIDTH-1:0] din_sh_q;
  logic [1:0]       sel_sh_d;
  logic [1:0]       sel_sh_q;
  logic             intr_d;
  logic             intr_q;

  // An unknown select falls into the default branch so the PC heads to the
  // reset vector rather than propagating X.
  always_comb begin
    DIN = ZERO_ADDR;
    case (PC_MUX_SEL)
      PC_SEL_IMMED: DIN = FROM_IMMED;
      PC_SEL_STACK: DIN = FROM_STACK;
      PC_SEL_INTR:  DIN = INTR_ADDR;
      PC_SEL_ZERO:  DIN = ZERO_ADDR;
      default:      DIN = ZERO_ADDR;
    endcase
  end

  // Level-based, not edge-detected: consecutive interrupt selects keep it high.
  always_comb begin
    din_sh_d = DIN;
    sel_sh_d = PC_MUX_SEL;
    intr_d   = (PC_MUX_SEL == PC_SEL_INTR);
  end

  // ---- shadow register stage ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      din_sh_q <= '0;
      sel_sh_q <= '0;
      intr_q   <= 1'b0;
    end else begin
      din_sh_q <= din_sh_d;
      sel_sh_q <= sel_sh_d;
      intr_q   <= intr_d;
    end
  end

  assign DIN_Q      = din_sh_q;
  assign SEL_Q      = sel_sh_q;
  assign INTR_TAKEN = intr_q;

`ifdef PC_MUX_TRACE_EN
  pc_mux_sat_cnt #(.CNT_W(16)) u_cnt_immed (
    .clk (CLK),
    .rst (RST),
    .en  (PC_MUX_SEL == PC_SEL_IMMED),
    .cnt (CNT_IMMED)
  );

  pc_mux_sat_cnt #(.CNT_W(16)) u_cnt_stack (
    .clk (CLK),
    .rst (RST),
    .en  (PC_MUX_SEL == PC_SEL_STACK),
    .cnt (CNT_STACK)
  );

  pc_mux_sat_cnt #(.CNT_W(16)) u_cnt_intr (
    .clk (CLK),
    .rst (RST),
    .en  (PC_MUX_SEL == PC_SEL_INTR),
    .cnt (CNT_INTR)
  );

  pc_mux_sat_cnt #(.CNT_W(16)) u_cnt_zero (
    .clk (CLK),
    .rst (RST),
    .en  (PC_MUX_SEL == PC_SEL_ZERO),
    .cnt (CNT_ZERO)
  );
`endif

endmodule

// File: tb/tb_pc_mux.sv
// tb_pc_mux: self-checking bench for pc_mux. A vector table covers the
// combinational select and the registered shadow; hand-written sequences
// cover mid-cycle reset, back-to-back interrupts and (with PC_MUX_TRACE_EN)
// the saturating counters.
module tb_pc_mux;

  logic       CLK;
  logic       RST;
  logic [9:0] FROM_IMMED;
  logic [9:0] FROM_STACK;
  logic [1:0] PC_MUX_SEL;
  logic [9:0] DIN;
  logic [9:0] DIN_Q;
  logic [1:0] SEL_Q;
  logic       INTR_TAKEN;
`ifdef PC_MUX_TRACE_EN
  logic [15:0] CNT_IMMED, CNT_STACK, CNT_INTR, CNT_ZERO;
`endif

  int checks = 0;
  int errors = 0;

  pc_mux dut (
    .CLK        (CLK),
    .RST        (RST),
    .FROM_IMMED (FROM_IMMED),
    .FROM_STACK (FROM_STACK),
    .PC_MUX_SEL (PC_MUX_SEL),
    .DIN        (DIN),
    .DIN_Q      (DIN_Q),
    .SEL_Q      (SEL_Q),
    .INTR_TAKEN (INTR_TAKEN)
`ifdef PC_MUX_TRACE_EN
    ,
    .CNT_IMMED  (CNT_IMMED),
    .CNT_STACK  (CNT_STACK),
    .CNT_INTR   (CNT_INTR),
    .CNT_ZERO   (CNT_ZERO)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] sel;
    logic [9:0] immed;
    logic [9:0] stack;
    logic [9:0] exp_din;
    logic       exp_intr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{2'd0, 10'b1110011001, 10'h000, 10'h399, 1'b0};
    vecs[1] = '{2'd1, 10'h399,        10'h000, 10'h000, 1'b0};
    vecs[2] = '{2'd2, 10'h399,        10'h000, 10'h3FF, 1'b1};
    vecs[3] = '{2'd3, 10'h399,        10'h2AA, 10'h000, 1'b0};
    vecs[4] = '{2'd1, 10'h000,        10'h2AA, 10'h2AA, 1'b0};
    vecs[5] = '{2'd0, 10'h155,        10'h3FF, 10'h155, 1'b0};
    vecs[6] = '{2'd2, 10'h000,        10'h000, 10'h3FF, 1'b1};
    vecs[7] = '{2'd1, 10'h001,        10'h3FE, 10'h3FE, 1'b0};

    RST        = 1'b1;
    FROM_IMMED = 10'h0;
    FROM_STACK = 10'h0;
    PC_MUX_SEL = 2'd0;
    #2;
    chk("reset_din_q", {22'd0, DIN_Q}, 32'h0);
    chk("reset_sel_q", {30'd0, SEL_Q}, 32'h0);
    chk("reset_intr",  {31'd0, INTR_TAKEN}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    // Table: combinational DIN, then the shadow one edge later
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      PC_MUX_SEL = vecs[i].sel;
      FROM_IMMED = vecs[i].immed;
      FROM_STACK = vecs[i].stack;
      #1;
      chk($sformatf("din_v%0d", i), {22'd0, DIN}, {22'd0, vecs[i].exp_din});
      @(posedge CLK);
      #1;
      chk($sformatf("din_q_v%0d", i), {22'd0, DIN_Q}, {22'd0, vecs[i].exp_din});
      chk($sformatf("sel_q_v%0d", i), {30'd0, SEL_Q}, {30'd0, vecs[i].sel});
      chk($sformatf("intr_v%0d", i), {31'd0, INTR_TAKEN}, {31'd0, vecs[i].exp_intr});
    end

    // SEL=3: changing STACK alone leaves DIN at the reset vector
    @(negedge CLK);
    PC_MUX_SEL = 2'd3;
    FROM_IMMED = 10'h399;
    FROM_STACK = 10'h2AA;
    #1;
    chk("sel3_din", {22'd0, DIN}, 32'h000);
    FROM_STACK = 10'h155;
    #1;
    chk("sel3_stack_chg", {22'd0, DIN}, 32'h000);

    // Mid-cycle asynchronous reset
    @(negedge CLK);
    PC_MUX_SEL = 2'd1;
    FROM_STACK = 10'h155;
    repeat (2) @(posedge CLK);
    #1;
    chk("pre_rst_din_q", {22'd0, DIN_Q}, 32'h155);
    chk("pre_rst_sel_q", {30'd0, SEL_Q}, 32'h1);
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_din_q", {22'd0, DIN_Q}, 32'h0);
    chk("async_rst_sel_q", {30'd0, SEL_Q}, 32'h0);
    chk("async_rst_intr",  {31'd0, INTR_TAKEN}, 32'h0);
    chk("async_rst_din",   {22'd0, DIN}, 32'h155);
    @(posedge CLK);
    #1;
    chk("rst_hold_din_q", {22'd0, DIN_Q}, 32'h0);
    chk("rst_hold_din",   {22'd0, DIN}, 32'h155);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("post_rst_din_q", {22'd0, DIN_Q}, 32'h155);
    chk("post_rst_sel_q", {30'd0, SEL_Q}, 32'h1);

    // Back-to-back interrupt selects: level, not edge
    @(negedge CLK);
    PC_MUX_SEL = 2'd2;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("intr_b2b_%0d", c), {31'd0, INTR_TAKEN}, 32'h1);
    end
    @(negedge CLK);
    PC_MUX_SEL = 2'd0;
    @(posedge CLK);
    #1;
    chk("intr_b2b_drop", {31'd0, INTR_TAKEN}, 32'h0);

`ifdef PC_MUX_TRACE_EN
    // Counters: exact counts, then saturation
    @(negedge CLK);
    RST = 1'b1;
    #1;
    RST = 1'b0;
    PC_MUX_SEL = 2'd0;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    PC_MUX_SEL = 2'd1;
    repeat (3) @(posedge CLK);
    #1;
    chk("cnt_immed_5", {16'd0, CNT_IMMED}, 32'd5);
    chk("cnt_stack_3", {16'd0, CNT_STACK}, 32'd3);
    chk("cnt_intr_0",  {16'd0, CNT_INTR},  32'd0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    RST = 1'b0;
    PC_MUX_SEL = 2'd0;
    repeat (70000) @(posedge CLK);
    #1;
    chk("cnt_immed_sat", {16'd0, CNT_IMMED}, 32'hFFFF);
    chk("cnt_stack_sat", {16'd0, CNT_STACK}, 32'h0);
    chk("cnt_intr_sat",  {16'd0, CNT_INTR},  32'h0);
    chk("cnt_zero_sat",  {16'd0, CNT_ZERO},  32'h0);
    RST = 1'b1;
    #1;
    chk("cnt_rst_immed", {16'd0, CNT_IMMED}, 32'h0);
    chk("cnt_rst_stack", {16'd0, CNT_STACK}, 32'h0);
    RST = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
